// File: rtl/tag_tree_update.sv
// Three-level 16-ary presence tree updater: sets or clears a tag's leaf bit and
// propagates occupancy changes towards the root through an external node memory.
module tag_tree_update #(
  parameter int TAG_W  = 12,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_ins,
  input  logic [TAG_W-1:0]  op_tag,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_WRITE, S_DONE} state_t;

  localparam logic [1:0] LVL_LEAF = 2'd0;
  localparam logic [1:0] LVL_MID  = 2'd1;
  localparam logic [1:0] LVL_ROOT = 2'd2;

  state_t             state_r, state_nx_s;
  logic [1:0]         level_r, level_nx_s;
  logic [TAG_W-1:0]   tag_r, tag_nx_s;
  logic               ins_r, ins_nx_s;
  logic [15:0]        old_r;
  logic [15:0]        bit_s, new_s;
  logic               err_s, stop_s;

  function automatic logic [ADDR_W-1:0] node_addr(input logic [1:0] lvl, input logic [TAG_W-1:0] tag);
    case (lvl)
      LVL_LEAF: node_addr = ADDR_W'(9'd17 + {1'b0, tag[11:4]});
      LVL_MID:  node_addr = ADDR_W'(9'd1 + {5'd0, tag[11:8]});
      default:  node_addr = {ADDR_W{1'b0}};
    endcase
  endfunction

  function automatic logic [3:0] node_digit(input logic [1:0] lvl, input logic [TAG_W-1:0] tag);
    case (lvl)
      LVL_LEAF: node_digit = tag[3:0];
      LVL_MID:  node_digit = tag[7:4];
      default:  node_digit = tag[11:8];
    endcase
  endfunction

  // mem_rdata is the old word only during CHECK; mem_wdata holds the new word during WRITE.
  assign bit_s  = 16'd1 << node_digit(level_r, tag_r);
  assign new_s  = ins_r ? (mem_rdata | bit_s) : (mem_rdata & ~bit_s);
  assign err_s  = (level_r == LVL_LEAF) &&
                  (ins_r ? (|(mem_rdata & bit_s)) : ~(|(mem_rdata & bit_s)));
  assign stop_s = (level_r == LVL_ROOT) ||
                  (ins_r ? (old_r != 16'd0) : (mem_wdata != 16'd0));

  // Next-state and next-context selection.
  always_comb begin
    state_nx_s = state_r;
    level_nx_s = level_r;
    tag_nx_s   = tag_r;
    ins_nx_s   = ins_r;
    case (state_r)
      S_IDLE: begin
        if (op_valid) begin
          state_nx_s = S_READ;
          level_nx_s = LVL_LEAF;
          tag_nx_s   = op_tag;
          ins_nx_s   = op_ins;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_READ:  state_nx_s = S_CHECK;
      S_CHECK: begin
        if (err_s) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_WRITE;
        end
      end
      S_WRITE: begin
        if (stop_s) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_READ;
          level_nx_s = level_r + 2'd1;
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State, context and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      level_r   <= LVL_LEAF;
      tag_r     <= {TAG_W{1'b0}};
      ins_r     <= 1'b0;
      old_r     <= 16'd0;
      op_ready  <= 1'b1;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= 16'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      level_r  <= level_nx_s;
      tag_r    <= tag_nx_s;
      ins_r    <= ins_nx_s;
      op_ready <= (state_nx_s == S_IDLE);
      mem_re   <= (state_nx_s == S_READ);
      mem_we   <= (state_nx_s == S_WRITE);
      done     <= (state_nx_s == S_DONE);
      err      <= (state_r == S_CHECK) && err_s;
      if (state_nx_s == S_READ) begin
        mem_addr <= node_addr(level_nx_s, tag_nx_s);
      end
      if (state_r == S_CHECK) begin
        old_r     <= mem_rdata;
        mem_wdata <= new_s;
      end
    end
  end

endmodule

// File: tb/tb_tag_tree_update.sv
// Directed bench for tag_tree_update: behavioural node memory plus a queue of
// expected writes checked as the DUT issues them.
module tb_tag_tree_update;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic        op_ins = 1'b0;
  logic [11:0] op_tag = 12'd0;
  logic        mem_re, mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'd0;
  logic        done, err;

  logic [15:0] mem [0:511];
  logic        mem_clr = 1'b1;
  logic        mon_en = 1'b0;
  logic [24:0] exp_q [$];
  int          vectors = 0;
  int          fails = 0;
  int          waits;

  tag_tree_update #(.TAG_W(12), .ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_ins(op_ins), .op_tag(op_tag), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Node memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 16'd0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [8:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // Write scoreboard and strobe protocol checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {23'd0, mem_addr}, 32'h0000_ffff);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          chk("write_addr", {23'd0, mem_addr}, {23'd0, e[24:16]});
          chk("write_data", {16'd0, mem_wdata}, {16'd0, e[15:0]});
        end
      end
      if (mem_re === 1'b1 || mem_we === 1'b1)
        chk("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
      if (err === 1'b1)
        chk("err_without_done", {31'd0, done}, 32'd1);
    end
  end

  // Entered at a negedge; drives a request, waits for acceptance, then for done.
  task automatic run_op(input logic ins, input logic [11:0] tag, input logic hold,
                        input int exp_cyc, input logic exp_err, output int nwait);
    bit seen;
    op_ins = ins;
    op_tag = tag;
    op_valid = 1'b1;
    nwait = 0;
    while (op_ready !== 1'b1 && nwait < 20) begin
      @(negedge clk);
      nwait++;
    end
    chk("ready_timeout", {31'd0, op_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) op_valid = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) chk("first_cycle_read", {31'd0, mem_re}, 32'd1);
      if (done === 1'b1) begin
        seen = 1'b1;
        chk("done_cycle", c, exp_cyc);
        chk("done_err", {31'd0, err}, {31'd0, exp_err});
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("writes_outstanding", exp_q.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    mem_clr = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Insert 0x123 into the empty tree: leaf 17+0x12, mid 1+0x1, root.
    push_wr(9'd35, 16'h0008); push_wr(9'd2, 16'h0004); push_wr(9'd0, 16'h0002);
    run_op(1'b1, 12'h123, 1'b0, 10, 1'b0, waits);
    @(negedge clk);

    push_wr(9'd35, 16'h0028);
    run_op(1'b1, 12'h125, 1'b0, 4, 1'b0, waits);
    chk("mid_untouched", {16'd0, mem[2]}, 32'h0004);
    chk("root_untouched", {16'd0, mem[0]}, 32'h0002);
    @(negedge clk);

    run_op(1'b1, 12'h123, 1'b0, 3, 1'b1, waits);
    @(negedge clk);

    push_wr(9'd35, 16'h0008);
    run_op(1'b0, 12'h125, 1'b0, 4, 1'b0, waits);
    @(negedge clk);

    push_wr(9'd35, 16'h0000); push_wr(9'd2, 16'h0000); push_wr(9'd0, 16'h0000);
    run_op(1'b0, 12'h123, 1'b0, 10, 1'b0, waits);
    @(negedge clk);

    run_op(1'b0, 12'h123, 1'b0, 3, 1'b1, waits);
    @(negedge clk);

    // Reset during the mid-level CHECK of insert 0x456 (cycle 5 after acceptance).
    push_wr(9'd86, 16'h0040);
    op_ins = 1'b1; op_tag = 12'h456; op_valid = 1'b1;
    chk("rst_test_ready", {31'd0, op_ready}, 32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_check_addr", {23'd0, mem_addr}, 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, op_ready}, 32'd1);
    chk("abort_no_write", {31'd0, mem_we}, 32'd0);
    chk("abort_leaf_written", exp_q.size(), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_leaf_word", {16'd0, mem[86]}, 32'h0040);
    chk("abort_mid_word", {16'd0, mem[5]}, 32'h0000);

    // op_valid held through an op, then back-to-back with a full 3-level insert.
    push_wr(9'd86, 16'h00c0);
    run_op(1'b1, 12'h457, 1'b1, 4, 1'b0, waits);
    chk("hold_waits", waits, 32'd0);
    push_wr(9'd188, 16'h1000); push_wr(9'd11, 16'h0800); push_wr(9'd0, 16'h0400);
    run_op(1'b1, 12'habc, 1'b0, 10, 1'b0, waits);
    chk("b2b_idle_cycles", waits, 32'd1);
    repeat (3) @(negedge clk);
    chk("final_idle_ready", {31'd0, op_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
